uart_pmux: RTL and testbench

//  8N1 UART with RX FIFO and in-band program-transfer escape. Received bytes go to
//  the CPU FIFO, except that MAGIC0 followed by MAGIC1 within a GUARD..TIMEOUT window

---
 rtl/uart_pmux.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_uart_pmux.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_pmux.sv
// uart_pmux: 8N1 UART with RX FIFO and MAGIC0/MAGIC1 escape into PROG mode.
// Define UART_PMUX_PROG_ECHO_EN to echo PROG-mode bytes back on tx.
module uart_pmux #(
  parameter int unsigned CLOCK_HZ     = 27000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter logic [7:0]  MAGIC0       = 8'h55,
  parameter logic [7:0]  MAGIC1       = 8'hAA,
  parameter int unsigned GUARD_US     = 200,
  parameter int unsigned TIMEOUT_US   = 20000,
  parameter int unsigned PROG_IDLE_US = 100000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  output logic                          tx,
  input  logic                          rd,
  output logic [7:0]                    rx_data,
  output logic                          rx_full,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_ovf,
  input  logic                          wr,
  input  logic [7:0]                    tx_data,
  output logic                          tx_ready,
  output logic                          prog_mode,
  output logic [7:0]                    prog_data,
  output logic                          prog_valid,
  input  logic                          prog_end
);

  localparam int unsigned DIV  = CLOCK_HZ / BAUD;
  localparam int unsigned HALF = DIV / 2;
  localparam int          AW   = $clog2(FIFO_DEPTH);

  localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(HALF - 1);

  localparam logic [63:0] GUARD_L =
    64'(CLOCK_HZ) * 64'(GUARD_US) / 64'd1000000;
  localparam logic [63:0] TOUT_L =
    64'(CLOCK_HZ) * 64'(TIMEOUT_US) / 64'd1000000;
  localparam logic [63:0] PIDLE_L =
    64'(CLOCK_HZ) * 64'(PROG_IDLE_US) / 64'd1000000;

  localparam logic [31:0] GUARD_C = GUARD_L[31:0];
  localparam logic [31:0] TOUT_C  = TOUT_L[31:0];
  localparam logic [31:0] PIDLE_C = PIDLE_L[31:0];

  localparam logic [AW:0] FULL_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    M_NORMAL,
    M_HOLD,
    M_PROG
  } mstate_t;

  // ---------------- RX ----------------
  // rx_sync[1] is the synchronised line, rx_sync[2] its previous value.
  logic [2:0]  rx_sync;
  logic        rx_s;
  logic        rx_fall;
  logic        rx_busy;
  logic [15:0] rx_cnt;
  logic [3:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        rx_evt;
  logic [7:0]  rx_byte;

  assign rx_s    = rx_sync[1];
  assign rx_fall = rx_sync[2] & ~rx_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync <= 3'b111;
    end else begin
      rx_sync <= {rx_sync[1:0], rx};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_busy <= 1'b0;
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
      rx_evt  <= 1'b0;
      rx_byte <= '0;
    end else begin
      rx_evt <= 1'b0;
      if (!rx_busy) begin
        if (rx_fall) begin
          rx_busy <= 1'b1;
          rx_cnt  <= HALF_M1;
          rx_bit  <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 1'b1;
      end else begin
        rx_cnt <= DIV_M1;
        rx_bit <= rx_bit + 1'b1;
        if (rx_bit == 4'd0) begin
          if (rx_s) rx_busy <= 1'b0;
        end else if (rx_bit == 4'd9) begin
          rx_busy <= 1'b0;
          rx_evt  <= rx_s;
          rx_byte <= rx_sh;
        end else begin
          rx_sh <= {rx_s, rx_sh[7:1]};
        end
      end
    end
  end

  // ---------------- mux FSM ----------------
  mstate_t     st, st_nx;
  logic [31:0] t;
  logic        t_clr;
  logic        pend_v, pend_ld;
  logic [7:0]  pend_b;
  logic        ev;
  logic [7:0]  ev_b;
  logic        push;
  logic [7:0]  push_b;
  logic        pv_nx;

  // A byte deferred out of HOLD is replayed through NORMAL next cycle.
  assign ev   = rx_evt | pend_v;
  assign ev_b = pend_v ? pend_b : rx_byte;

  always_comb begin
    st_nx   = st;
    push    = 1'b0;
    push_b  = ev_b;
    t_clr   = 1'b0;
    pend_ld = 1'b0;
    pv_nx   = 1'b0;
    unique case (st)
      M_NORMAL: begin
        if (ev) begin
          if (ev_b == MAGIC0) begin
            st_nx = M_HOLD;
            t_clr = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
      end
      M_HOLD: begin
        if (rx_evt || t == TOUT_C) begin
          if (rx_evt && t >= GUARD_C && t < TOUT_C &&
              rx_byte == MAGIC1) begin
            st_nx = M_PROG;
            t_clr = 1'b1;
          end else begin
            push    = 1'b1;
            push_b  = MAGIC0;
            pend_ld = rx_evt;
            st_nx   = M_NORMAL;
          end
        end
      end
      M_PROG: begin
        if (rx_evt) begin
          pv_nx = 1'b1;
          t_clr = 1'b1;
        end
        if (prog_end || t == PIDLE_C) st_nx = M_NORMAL;
      end
      default: st_nx = M_NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= M_NORMAL;
      t          <= '0;
      pend_v     <= 1'b0;
      pend_b     <= '0;
      prog_valid <= 1'b0;
      prog_data  <= '0;
    end else begin
      st         <= st_nx;
      pend_v     <= pend_ld;
      prog_valid <= pv_nx;
      if (pend_ld) pend_b <= rx_byte;
      if (pv_nx) prog_data <= rx_byte;
      if (t_clr) t <= '0;
      else if (st != M_NORMAL) t <= t + 1'b1;
    end
  end

  assign prog_mode = (st == M_PROG);

  // ---------------- FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          pop, full, wr_ok, drop;

  assign pop   = rd && (cnt != '0);
  assign full  = (cnt == FULL_C);
  assign wr_ok = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '{default: '0};
    end else if (wr_ok) begin
      mem[wp] <= push_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp     <= '0;
      rp     <= '0;
      cnt    <= '0;
      rx_ovf <= 1'b0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (wr_ok && !pop) cnt <= cnt + 1'b1;
      else if (!wr_ok && pop) cnt <= cnt - 1'b1;
      if (drop) rx_ovf <= 1'b1;
      else if (rd) rx_ovf <= 1'b0;
    end
  end

  assign rx_full  = (cnt != '0);
  assign rx_count = cnt;
  assign rx_data  = rx_full ? mem[rp] : 8'h00;

  // ---------------- TX ----------------
  logic        tx_busy;
  logic [15:0] tx_cnt;
  logic [3:0]  tx_bit;
  logic [9:0]  tx_sh;
  logic        tx_go;
  logic [7:0]  tx_go_b;

`ifdef UART_PMUX_PROG_ECHO_EN
  logic       echo_v;
  logic [7:0] echo_b;
  logic       echo_go;

  assign echo_go  = !tx_busy && echo_v;
  assign tx_ready = !tx_busy && !prog_mode && !echo_v;
  assign tx_go    = echo_go || (wr && tx_ready);
  assign tx_go_b  = echo_go ? echo_b : tx_data;

  // New prog byte overwrites a still-pending echo.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_v <= 1'b0;
      echo_b <= '0;
    end else if (pv_nx) begin
      echo_v <= 1'b1;
      echo_b <= rx_byte;
    end else if (echo_go) begin
      echo_v <= 1'b0;
    end
  end
`else
  assign tx_ready = !tx_busy;
  assign tx_go    = wr && tx_ready;
  assign tx_go_b  = tx_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy <= 1'b0;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '1;
    end else if (!tx_busy) begin
      if (tx_go) begin
        tx_busy <= 1'b1;
        tx_cnt  <= DIV_M1;
        tx_bit  <= '0;
        tx_sh   <= {1'b1, tx_go_b, 1'b0};
      end
    end else if (tx_cnt != '0) begin
      tx_cnt <= tx_cnt - 1'b1;
    end else begin
      tx_cnt <= DIV_M1;
      tx_sh  <= {1'b1, tx_sh[9:1]};
      if (tx_bit == 4'd9) tx_busy <= 1'b0;
      else tx_bit <= tx_bit + 1'b1;
    end
  end

  assign tx = tx_busy ? tx_sh[0] : 1'b1;

endmodule

// File: tb/tb_uart_pmux.sv
// tb_uart_pmux: directed bench for uart_pmux at DIV=10 (1.152 MHz / 115200).
// Escape windows: GUARD=230, TIMEOUT=23040 clk.
module tb_uart_pmux;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       tx;
  logic       rd = 1'b0;
  logic [7:0] rx_data;
  logic       rx_full;
  logic [4:0] rx_count;
  logic       rx_ovf;
  logic       wr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       prog_mode;
  logic [7:0] prog_data;
  logic       prog_valid;
  logic       prog_end = 1'b0;

  int total = 0;
  int bad = 0;

  int         pv_n = 0;
  logic [7:0] pv_b [8];

  always #434 clk = ~clk;

  uart_pmux #(
    .CLOCK_HZ(1152000),
    .BAUD(115200)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .tx(tx),
    .rd(rd),
    .rx_data(rx_data),
    .rx_full(rx_full),
    .rx_count(rx_count),
    .rx_ovf(rx_ovf),
    .wr(wr),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .prog_mode(prog_mode),
    .prog_data(prog_data),
    .prog_valid(prog_valid),
    .prog_end(prog_end)
  );

  always @(negedge clk) begin
    if (prog_valid) begin
      if (pv_n < 8) pv_b[pv_n] = prog_data;
      pv_n = pv_n + 1;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      cyc(DIV);
    end
  endtask

  task automatic pop;
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
  endtask

  initial begin
    logic [9:0] exp_f;

    cyc(3);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_txrdy", 32'(tx_ready), 32'd1);
    check("rst_full", 32'(rx_full), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_cnt", 32'(rx_count), 32'd0);
    check("rst_ovf", 32'(rx_ovf), 32'd0);
    check("rst_pm", 32'(prog_mode), 32'd0);
    check("rst_pv", 32'(prog_valid), 32'd0);
    check("rst_pd", 32'(prog_data), 32'd0);
    rst_n = 1'b1;
    cyc(3);

    // 1: plain byte
    send(8'h61);
    cyc(1);
    check("t1_full", 32'(rx_full), 32'd1);
    check("t1_data", 32'(rx_data), 32'h61);
    pop();
    check("t1_empty", 32'(rx_full), 32'd0);

    // 2: escape pair too close together
    send(8'h55);
    send(8'hAA);
    cyc(5);
    check("t2_cnt", 32'(rx_count), 32'd2);
    check("t2_d0", 32'(rx_data), 32'h55);
    pop();
    check("t2_d1", 32'(rx_data), 32'hAA);
    pop();
    check("t2_empty", 32'(rx_full), 32'd0);
    check("t2_pm", 32'(prog_mode), 32'd0);

    // 3: lone MAGIC0 released by timeout
    send(8'h55);
    cyc(20000);
    check("t3_held", 32'(rx_full), 32'd0);
    cyc(3100);
    check("t3_full", 32'(rx_full), 32'd1);
    check("t3_data", 32'(rx_data), 32'h55);
    check("t3_pm", 32'(prog_mode), 32'd0);
    pop();

    // 4: valid escape, three prog bytes, loader ends
    send(8'h55);
    cyc(1152);
    send(8'hAA);
    cyc(1);
    check("t4_pm", 32'(prog_mode), 32'd1);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    cyc(2);
    check("t4_pvn", 32'(pv_n), 32'd3);
    check("t4_pv0", 32'(pv_b[0]), 32'h01);
    check("t4_pv1", 32'(pv_b[1]), 32'h02);
    check("t4_pv2", 32'(pv_b[2]), 32'h03);
    check("t4_fifo", 32'(rx_count), 32'd0);
    prog_end = 1'b1;
    cyc(1);
    prog_end = 1'b0;
    check("t4_exit", 32'(prog_mode), 32'd0);
    send(8'h61);
    cyc(1);
    check("t4_back", 32'(rx_data), 32'h61);
    check("t4_cnt", 32'(rx_count), 32'd1);
    pop();

    // 5: overflow
    for (int i = 0; i <= 16; i++) send(8'(i));
    cyc(2);
    check("t5_cnt", 32'(rx_count), 32'd16);
    check("t5_ovf", 32'(rx_ovf), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t5_d%0d", i), 32'(rx_data), 32'(i));
      pop();
      if (i == 0) check("t5_ovfclr", 32'(rx_ovf), 32'd0);
    end
    check("t5_empty", 32'(rx_full), 32'd0);

    // 6: transmit 0x41, then reset mid-frame
    exp_f = 10'b1010000010;
    tx_data = 8'h41;
    wr = 1'b1;
    cyc(1);
    wr = 1'b0;
    check("t6_busy", 32'(tx_ready), 32'd0);
    cyc(5);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t6_bit%0d", i), 32'(tx), 32'(exp_f[i]));
      if (i < 9) cyc(DIV);
    end
    check("t6_busy95", 32'(tx_ready), 32'd0);
    cyc(5);
    check("t6_ready", 32'(tx_ready), 32'd1);
    check("t6_idle", 32'(tx), 32'd1);
    tx_data = 8'h00;
    wr = 1'b1;
    cyc(1);
    wr = 1'b0;
    cyc(4);
    check("t6_start", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_tx", 32'(tx), 32'd1);
    check("t6_rst_rdy", 32'(tx_ready), 32'd1);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
